// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM encoding, port count.
// Holds the 4-bit ALU datapath as a pure function so it is evaluated in exactly one place.
package alu_share_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Compare ops return a 3-bit marker in the upper bits so results stay distinguishable.
  function automatic logic [3:0] alu_eval(input logic [2:0] op,
                                          input logic [3:0] rs,
                                          input logic [3:0] rt);
    logic [3:0] res;
    res = 4'h0;
    case (op)
      OP_SUB:  res = rs - rt;
      OP_ADD:  res = rs + rt;
      OP_OR:   res = rs | rt;
      OP_AND:  res = rs & rt;
      OP_SRA:  res = {rt[3], rt[3:1]};
      OP_ROL:  res = {rs[2:0], rs[3]};
      OP_LT:   res = {3'b101, (rs < rt)};
      OP_EQ:   res = {3'b111, (rs == rt)};
      default: res = 4'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that was not granted last wins.
// Zero latency; grant_oh is zero when no port is valid.
module alu_rr_pick
  import alu_share_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 last_grant,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic                 grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    grant_oh  = 2'b00;
    if (valid == 2'b11) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = valid[1];
    end
    if (valid != 2'b00) begin
      grant_oh = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin sequencer for one shared 4-bit ALU; accept -> rsp_valid one edge later, 3 cycles/op.
// Only one request in flight; req_ready stays low until the granted port takes its response.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int RR_INIT = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [5:0]           req_op,
  input  logic [7:0]           req_rs,
  input  logic [7:0]           req_rt,
  output logic [NUM_PORTS-1:0] rsp_valid,
  input  logic [NUM_PORTS-1:0] rsp_ready,
  output logic [3:0]           rsp_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  // Reset value makes RR_INIT the winner of the first tie.
  localparam logic LAST_INIT = (RR_INIT == 0);

  state_t               state;
  logic                 last_grant;
  logic                 grant_q;
  logic [2:0]           op_q;
  logic [3:0]           rs_q;
  logic [3:0]           rt_q;
  logic [NUM_PORTS-1:0] pick_oh;
  logic                 pick_idx;
  logic                 req_hs;
  logic [2:0]           sel_op;
  logic [3:0]           sel_rs;
  logic [3:0]           sel_rt;
  logic [3:0]           alu_res;

  alu_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx)
  );

  assign req_ready = (state == ST_IDLE) ? pick_oh : 2'b00;
  assign req_hs    = |(req_valid & req_ready);
  assign busy      = (state != ST_IDLE);

  assign sel_op = pick_idx ? req_op[5:3] : req_op[2:0];
  assign sel_rs = pick_idx ? req_rs[7:4] : req_rs[3:0];
  assign sel_rt = pick_idx ? req_rt[7:4] : req_rt[3:0];

  // The ALU only ever sees the latched operands, never the live request buses.
  assign alu_res = alu_eval(op_q, rs_q, rt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= LAST_INIT;
      grant_q    <= 1'b0;
      op_q       <= 3'b000;
      rs_q       <= 4'h0;
      rt_q       <= 4'h0;
      rsp_valid  <= 2'b00;
      rsp_data   <= 4'h0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            op_q       <= sel_op;
            rs_q       <= sel_rs;
            rt_q       <= sel_rt;
            grant_q    <= pick_idx;
            last_grant <= pick_idx;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_res;
          rsp_valid <= grant_q ? 2'b10 : 2'b01;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid <= 2'b00;
            if (op_count != {CNT_W{1'b1}}) begin
              op_count <= op_count + CNT_W'(1);
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with hand-computed expectations.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req_op;
  logic [7:0] req_rs;
  logic [7:0] req_rt;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;
  logic [7:0] op_count;

  int passed = 0;
  int total  = 0;
  int exp_count = 0;

  logic [15:0] vec [10];

  always #5 clk = ~clk;

  alu_share_arbiter #(.RR_INIT(0), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int p, input logic [2:0] op, input logic [3:0] rs,
                         input logic [3:0] rt);
    if (p == 1) begin
      req_op[5:3] = op; req_rs[7:4] = rs; req_rt[7:4] = rt; req_valid[1] = 1'b1;
    end else begin
      req_op[2:0] = op; req_rs[3:0] = rs; req_rt[3:0] = rt; req_valid[0] = 1'b1;
    end
  endtask

  // Wait (bounded) for a response, check it, then complete it with a one-cycle rsp_ready.
  task automatic expect_rsp(input int p, input logic [3:0] d, input bit drop, input string tag);
    int n;
    logic [1:0] oh;
    n  = 0;
    oh = (p == 1) ? 2'b10 : 2'b01;
    while (rsp_valid == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, rsp_valid, oh);
    check({tag, "_dat"}, rsp_data, d);
    if (drop) req_valid = 2'b00;
    rsp_ready = oh;
    tick();
    rsp_ready = 2'b00;
    exp_count++;
    check({tag, "_cnt"}, op_count, exp_count);
    check({tag, "_rel"}, rsp_valid, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    bit inc;
    bit stray;

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_rs = '0; req_rt = '0;
    tick();
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", op_count, 8'h00);
    check("rst_req_ready", req_ready, 2'b00);
    rst_n = 1'b1;
    tick();

    // Single request on port 0: 7 + 5 = C.
    set_req(0, 3'b001, 4'd7, 4'd5);
    #1;
    check("p0_req_ready", req_ready, 2'b01);
    tick();
    check("p0_busy", busy, 1'b1);
    check("p0_exec_ready", req_ready, 2'b00);
    check("p0_exec_vld", rsp_valid, 2'b00);
    req_valid = 2'b00;
    tick();
    check("p0_vld", rsp_valid, 2'b01);
    check("p0_dat", rsp_data, 4'hC);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("p0_rel", rsp_valid, 2'b00);
    check("p0_cnt", op_count, 8'd1);
    check("p0_idle", busy, 1'b0);

    // Tie right after reset: 0, 1, 0 with 3 - 5 = E.
    do_reset();
    set_req(0, 3'b000, 4'd3, 4'd5);
    set_req(1, 3'b000, 4'd3, 4'd5);
    expect_rsp(0, 4'hE, 1'b0, "tie1");
    expect_rsp(1, 4'hE, 1'b0, "tie2");
    expect_rsp(0, 4'hE, 1'b1, "tie3");

    // Opcode vectors on port 1: {op, rs, rt, result}.
    vec = '{ {1'b0, 3'b110, 4'd2,  4'd9,  4'hB},
             {1'b0, 3'b111, 4'd6,  4'd6,  4'hF},
             {1'b0, 3'b100, 4'd0,  4'h8,  4'hC},
             {1'b0, 3'b010, 4'hA,  4'h5,  4'hF},
             {1'b0, 3'b011, 4'hC,  4'hA,  4'h8},
             {1'b0, 3'b101, 4'h9,  4'h0,  4'h3},
             {1'b0, 3'b000, 4'd2,  4'd7,  4'hB},
             {1'b0, 3'b001, 4'hF,  4'h1,  4'h0},
             {1'b0, 3'b110, 4'd9,  4'd2,  4'hA},
             {1'b0, 3'b111, 4'd6,  4'd7,  4'hE} };
    for (int i = 0; i < 10; i++) begin
      set_req(1, vec[i][14:12], vec[i][11:8], vec[i][7:4]);
      expect_rsp(1, vec[i][3:0], 1'b1, $sformatf("op%0d", i));
    end

    // Stalled response on port 0 with port 1 waiting; port 1's rsp_ready must be ignored.
    set_req(0, 3'b001, 4'd1, 4'd2);
    tick();
    set_req(1, 3'b011, 4'hF, 4'h6);
    tick();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_vld%0d", i), rsp_valid, 2'b01);
      check($sformatf("stall_dat%0d", i), rsp_data, 4'h3);
      check($sformatf("stall_rdy%0d", i), req_ready, 2'b00);
      tick();
    end
    req_valid[0] = 1'b0;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    exp_count++;
    check("stall_cnt", op_count, exp_count);
    check("stall_p1_ready", req_ready, 2'b10);
    tick();
    check("stall_p1_busy", busy, 1'b1);
    req_valid = 2'b00;
    expect_rsp(1, 4'h6, 1'b1, "stall_p1");

    // Reset during EXEC aborts the transaction.
    set_req(0, 3'b001, 4'd1, 4'd1);
    tick();
    check("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_vld", rsp_valid, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_cnt", op_count, 8'h00);
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid != 2'b00 || busy) stray = 1'b1;
    end
    check("abort_no_stray", stray, 1'b0);

    // 260 back-to-back ops with rsp_ready tied high: counter saturates.
    rsp_ready = 2'b11;
    set_req(0, 3'b000, 4'd0, 4'd1);
    n = 0;
    cyc = 0;
    while (n < 260 && cyc < 2000) begin
      inc = rsp_valid[0];
      if (inc) n++;
      tick();
      cyc++;
      if (inc && n == 254) check("sat_254", op_count, 8'hFE);
      if (inc && n == 256) check("sat_256", op_count, 8'hFF);
    end
    req_valid = 2'b00;
    check("sat_ops_done", n, 260);
    check("sat_cnt", op_count, 8'hFF);
    tick();
    tick();
    rsp_ready = 2'b00;
    check("sat_idle", busy, 1'b0);
    check("sat_cnt_hold", op_count, 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
